// File: rtl/mult_sequencer.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle over a
// 2*WIDTH accumulator, signed operands handled as magnitudes plus a final negate.
module mult_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      ONE_CNT  = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1);
   localparam logic [WIDTH-1:0]   ZERO_W   = '0;
   localparam logic [2*WIDTH-1:0] ZERO_P   = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_r;
   logic [WIDTH-1:0]    mcand_r;
   logic [WIDTH-1:0]    mplier_r;
   logic                neg_r;
   logic [2*WIDTH-1:0]  acc_r;
   logic [CW-1:0]       count_r;
   logic                busy_r;
   logic                done_r;
   logic [2*WIDTH-1:0]  product_r;

   logic                a_neg_s;
   logic                b_neg_s;
   logic [WIDTH-1:0]    a_mag_s;
   logic [WIDTH-1:0]    b_mag_s;
   logic                zero_op_s;
   logic [2*WIDTH-1:0]  addend_s;
   logic [2*WIDTH-1:0]  acc_next_s;
   logic [2*WIDTH-1:0]  result_s;

   // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
   always_comb begin
      a_neg_s   = signed_mode & a[WIDTH-1];
      b_neg_s   = signed_mode & b[WIDTH-1];
      zero_op_s = (a == ZERO_W) || (b == ZERO_W);
      if (a_neg_s) begin
         a_mag_s = ~a + ONE_W;
      end else begin
         a_mag_s = a;
      end
      if (b_neg_s) begin
         b_mag_s = ~b + ONE_W;
      end else begin
         b_mag_s = b;
      end
   end

   // One shift-and-add step plus the sign-corrected value of the final step
   always_comb begin
      addend_s = ZERO_P;
      if (mplier_r[count_r]) begin
         addend_s = {ZERO_W, mcand_r} << count_r;
      end else begin
         addend_s = ZERO_P;
      end
      acc_next_s = acc_r + addend_s;
      if (neg_r) begin
         result_s = ~acc_next_s + ONE_P;
      end else begin
         result_s = acc_next_s;
      end
   end

   // Sequencer state, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         mcand_r   <= ZERO_W;
         mplier_r  <= ZERO_W;
         neg_r     <= 1'b0;
         acc_r     <= ZERO_P;
         count_r   <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= ZERO_P;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  mcand_r  <= a_mag_s;
                  mplier_r <= b_mag_s;
                  neg_r    <= a_neg_s ^ b_neg_s;
                  acc_r    <= ZERO_P;
                  count_r  <= '0;
                  busy_r   <= 1'b1;
                  if (zero_op_s) begin
                     product_r <= ZERO_P;
                     done_r    <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     state_r   <= CALC;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            CALC: begin
               acc_r   <= acc_next_s;
               count_r <= count_r + ONE_CNT;
               if (count_r == LAST_CNT) begin
                  product_r <= result_s;
                  done_r    <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  state_r   <= CALC;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer (WIDTH=32): expected products queued at
// accept, popped when done is seen; latency, hold and busy behaviour checked inline.
module tb_mult_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        signed_mode;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int          checks;
   int          errors;
   int          accepts;
   int          done_cnt;
   logic [63:0] last_prod;
   logic [63:0] exp_q[$];

   mult_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .product(product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic signed [63:0] sp;
      if (s) begin
         sx = {{32{x[31]}}, x};
         sy = {{32{y[31]}}, y};
         sp = sx * sy;
         return sp;
      end
      return {32'd0, x} * {32'd0, y};
   endfunction

   // Caller must be at a negedge; start is driven immediately.
   task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic ism,
                        input string tag);
      int          lat;
      int          exp_lat;
      logic [63:0] exp_p;
      exp_lat = (ia == 32'd0 || ib == 32'd0) ? 1 : 33;
      a = ia; b = ib; signed_mode = ism; start = 1'b1;
      exp_q.push_back(ref_mul(ia, ib, ism));
      accepts++;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; signed_mode = 1'($urandom_range(0, 1));
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
      end
      if (exp_lat == 33) begin
         checks++;
         if (product !== last_prod) begin
            errors++;
            $display("FAIL %s product_hold: got %h want %h", tag, product, last_prod);
         end
      end
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard_empty: got 0 entries want 1", tag);
      end else begin
         exp_p = exp_q.pop_front();
         if (product !== exp_p) begin
            errors++;
            $display("FAIL %s product: got %h want %h", tag, product, exp_p);
         end
         last_prod = exp_p;
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after_done: got done=%b busy=%b want 0 0", tag, done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = 32'd0; b = 32'd0;
      #3;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b product=%h want 0 0 0",
                  busy, done, product);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_prod = 64'd0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_op(32'd7, 32'd6, 1'b0, "unsigned_7x6");
      do_op(32'hFFFFFFFD, 32'd5, 1'b1, "signed_m3x5");
      do_op(32'h80000000, 32'h80000000, 1'b1, "signed_min_sq");
      do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "unsigned_max_sq");
      do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "signed_m1_sq");
      do_op(32'd0, 32'd123, 1'b0, "zero_a");
      do_op(32'd55, 32'd0, 1'b1, "zero_b");
   endtask

   task automatic test_ignored_start();
      int dc0;
      int lat;
      dc0 = done_cnt;
      a = 32'd2; b = 32'd3; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 7;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 33 || product !== 64'd6) begin
         errors++;
         $display("FAIL ignored_start_result: got lat=%0d product=%h want 33 6", lat, product);
      end
      last_prod = 64'd6;
      @(negedge clk);
      do_op(32'd5, 32'd7, 1'b0, "first_idle_accept");
      checks++;
      if (done_cnt - dc0 !== 2) begin
         errors++;
         $display("FAIL ignored_start_done_count: got %0d want 2", done_cnt - dc0);
      end
   endtask

   task automatic test_reset_midop();
      int dc0;
      a = 32'd100; b = 32'd100; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         errors++;
         $display("FAIL reset_midop_async: got busy=%b done=%b product=%h want 0 0 0",
                  busy, done, product);
      end
      dc0 = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (done_cnt !== dc0 || product !== 64'd0) begin
         errors++;
         $display("FAIL reset_midop_no_done: got %0d pulses product=%h want 0 0",
                  done_cnt - dc0, product);
      end
      last_prod = 64'd0;
      do_op(32'd4, 32'd4, 1'b0, "after_reset_4x4");
   endtask

   task automatic test_random();
      int          acc0;
      int          dc0;
      logic [31:0] ra;
      logic [31:0] rb;
      acc0 = accepts;
      dc0  = done_cnt;
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 7))
            0:       begin ra = 32'd0;        rb = $urandom; end
            1:       begin ra = 32'h80000000; rb = $urandom; end
            2:       begin ra = $urandom;     rb = 32'hFFFFFFFF; end
            default: begin ra = $urandom;     rb = $urandom; end
         endcase
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_op(ra, rb, 1'($urandom_range(0, 1)), "random");
      end
      checks++;
      if (done_cnt - dc0 !== accepts - acc0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_done_count: got %0d done %0d queued want %0d done 0 queued",
                  done_cnt - dc0, exp_q.size(), accepts - acc0);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      accepts  = 0;
      done_cnt = 0;
      test_reset();
      test_basic();
      test_ignored_start();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
